// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
// Provides the FSM state enum, requester IDs and the fixed fetch size.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } arb_state_e;

  // Value doubles as the bit index in grant/request vectors.
  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic [2:0] IFU_SIZE = 3'b011;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// ram_arb_rr_pick: combinational 2-way round-robin picker.
// Ports: i_req {lsu,ifu}, i_last last granted ID, o_grant one-hot.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_e    i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    // On a tie the requester not served last wins.
    if (i_req == 2'b11) begin
      o_grant = (i_last == REQ_IFU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_rw_arbiter.sv
// ram_rw_arbiter: shares one RAM rw port between IFU (read) and LSU (r/w).
// Ports: ifu_* fetch side, lsu_* load/store side, ram_rw_* RAM side,
// arb_err_o sticky watchdog flag. All outputs registered.
module ram_rw_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_ready_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_wen_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  input  logic [2:0]          lsu_size_i,
  output logic                lsu_ready_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                ram_rw_cen_o,
  output logic                ram_rw_wen_o,
  output logic [ADDR_W-1:0]   ram_rw_addr_o,
  output logic [DATA_W-1:0]   ram_rw_wdata_o,
  output logic [DATA_W/8-1:0] ram_rw_wmask_o,
  output logic [2:0]          ram_rw_size_o,
  input  logic                ram_rw_ready_i,
  input  logic [DATA_W-1:0]   ram_rw_data_i,
  output logic                arb_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    r_state;
  req_id_e       r_last;
  req_id_e       r_owner;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_tmo;
  logic          w_done;

  assign w_req = {lsu_req_i, ifu_req_i};

  ram_arb_rr_pick u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_gnt)
  );

  // Saturating watchdog; abort on the cycle it reaches TIMEOUT.
  assign w_cnt_nxt = (r_cnt == CW'(TIMEOUT)) ? r_cnt
                                             : r_cnt + CW'(1);
  assign w_tmo  = (w_cnt_nxt == CW'(TIMEOUT));
  assign w_done = ram_rw_ready_i | w_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last         <= REQ_IFU;
      r_owner        <= REQ_IFU;
      r_cnt          <= '0;
      ifu_ready_o    <= 1'b0;
      ifu_rdata_o    <= '0;
      lsu_ready_o    <= 1'b0;
      lsu_rdata_o    <= '0;
      ram_rw_cen_o   <= 1'b0;
      ram_rw_wen_o   <= 1'b0;
      ram_rw_addr_o  <= '0;
      ram_rw_wdata_o <= '0;
      ram_rw_wmask_o <= '0;
      ram_rw_size_o  <= '0;
      arb_err_o      <= 1'b0;
    end else begin
      ifu_ready_o <= 1'b0;
      lsu_ready_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state      <= BUSY;
            r_cnt        <= '0;
            ram_rw_cen_o <= 1'b1;
            if (w_gnt[1]) begin
              r_owner        <= REQ_LSU;
              r_last         <= REQ_LSU;
              ram_rw_wen_o   <= lsu_wen_i;
              ram_rw_addr_o  <= lsu_addr_i;
              ram_rw_wdata_o <= lsu_wdata_i;
              ram_rw_wmask_o <= lsu_wmask_i;
              ram_rw_size_o  <= lsu_size_i;
            end else begin
              r_owner        <= REQ_IFU;
              r_last         <= REQ_IFU;
              ram_rw_wen_o   <= 1'b0;
              ram_rw_addr_o  <= ifu_addr_i;
              ram_rw_wdata_o <= '0;
              ram_rw_wmask_o <= '0;
              ram_rw_size_o  <= IFU_SIZE;
            end
          end
        end
        BUSY: begin
          r_cnt <= w_cnt_nxt;
          if (w_done) begin
            r_state      <= GAP;
            ram_rw_cen_o <= 1'b0;
            ram_rw_wen_o <= 1'b0;
            // A real ready wins over a same-cycle timeout.
            if (!ram_rw_ready_i) begin
              arb_err_o <= 1'b1;
            end
            if (r_owner == REQ_LSU) begin
              lsu_ready_o <= 1'b1;
              if (!ram_rw_ready_i) begin
                lsu_rdata_o <= '0;
              end else if (!ram_rw_wen_o) begin
                lsu_rdata_o <= ram_rw_data_i;
              end
            end else begin
              ifu_ready_o <= 1'b1;
              ifu_rdata_o <= ram_rw_ready_i ? ram_rw_data_i : '0;
            end
          end
        end
        // One cen-low cycle so the RAM's delayed ready cannot leak
        // into the next transaction.
        GAP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
